vcu_insn_sequencer: RTL

VCU_INSN_SEQUENCER -- requirements
Module: vcu_insn_sequencer

---
 rtl/vcu_seq_pkg.sv | 19 +
 rtl/vcu_insn_fifo.sv | 58 +++++
 rtl/vcu_insn_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/vcu_seq_pkg.sv
// Shared types and default parameter values for the VCU instruction sequencer.
package vcu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_FINISH
  } seq_state_e;

  localparam int DEF_INSN_WIDTH          = 128;
  localparam int DEF_FIFO_DEPTH          = 16;
  localparam int DEF_OFMAP_ADDRESS_WIDTH = 12;
  localparam int DEF_OFMAP_DATA_WIDTH    = 512;
  localparam int DEF_KICK_EACH           = 1;
  localparam int DEF_TIMEOUT_CYCLES      = 65535;

endpackage

// File: rtl/vcu_insn_fifo.sv
// Synchronous instruction queue with registered fill level and synchronous flush.
module vcu_insn_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately left unreset; pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vcu_insn_sequencer.sv
// Issues queued instructions to the VCU one at a time, then drains the ofmap buffer
// onto a ready/valid stream; bounded wait on vcu_done with sticky timeout flag.
module vcu_insn_sequencer
  import vcu_seq_pkg::*;
#(
  parameter int INSN_WIDTH          = DEF_INSN_WIDTH,
  parameter int FIFO_DEPTH          = DEF_FIFO_DEPTH,
  parameter int OFMAP_ADDRESS_WIDTH = DEF_OFMAP_ADDRESS_WIDTH,
  parameter int OFMAP_DATA_WIDTH    = DEF_OFMAP_DATA_WIDTH,
  parameter int KICK_EACH           = DEF_KICK_EACH,
  parameter int TIMEOUT_CYCLES      = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INSN_WIDTH-1:0]          insn_in,
  input  logic                           insn_in_valid,
  output logic                           insn_in_ready,
  input  logic                           start,
  input  logic [15:0]                    num_insn,
  input  logic [OFMAP_ADDRESS_WIDTH:0]   data_num,
  input  logic                           abort,
  output logic [INSN_WIDTH-1:0]          insn,
  output logic                           work_en,
  input  logic                           vcu_done,
  output logic [OFMAP_ADDRESS_WIDTH-1:0] r_addr_ofmap,
  output logic                           r_en_ofmap,
  input  logic [OFMAP_DATA_WIDTH-1:0]    r_data_ofmap,
  output logic [OFMAP_DATA_WIDTH-1:0]    out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           run_done,
  output logic                           err_timeout,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int AW = OFMAP_ADDRESS_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e                  state, state_nxt;
  logic [INSN_WIDTH-1:0]       fifo_head;
  logic                        fifo_full, fifo_empty, pop, do_read;
  logic [15:0]                 num_insn_q, issued_cnt;
  logic [AW:0]                 data_num_q, rd_cnt, acc_cnt;
  logic [TW-1:0]               timer;
  logic                        vcu_done_d, done_rise, timed_out;
  logic                        pending, skid_valid, out_free, consume;
  logic [OFMAP_DATA_WIDTH-1:0] skid_data;
  logic [1:0]                  in_use;

  vcu_insn_fifo #(.WIDTH(INSN_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (insn_in_valid),
    .din   (insn_in),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign insn_in_ready = !fifo_full;
  assign busy          = (state != S_IDLE);
  assign run_done      = (state == S_FINISH);
  assign r_en_ofmap    = do_read;
  assign r_addr_ofmap  = rd_cnt[AW-1:0];
  assign done_rise     = vcu_done && !vcu_done_d;
  assign timed_out     = !done_rise && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign out_free      = !out_valid || out_ready;
  assign consume       = out_valid && out_ready;
  // Words held or in flight after this cycle's hand-off; the skid slot absorbs the
  // read that is already in flight when the consumer stalls.
  assign in_use = 2'(out_valid) + 2'(skid_valid) + 2'(pending) - 2'(consume);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    do_read   = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = (num_insn == 16'd0) ? S_DRAIN : S_ISSUE;
      S_ISSUE:  if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = S_WAIT;
                end
      S_WAIT:   if (done_rise)
                  state_nxt = (issued_cnt + 16'd1 == num_insn_q) ? S_DRAIN : S_ISSUE;
                else if (timed_out)
                  state_nxt = S_FINISH;
      S_DRAIN:  if (acc_cnt == data_num_q) state_nxt = S_FINISH;
                else if (rd_cnt < data_num_q && in_use < 2'd2) do_read = 1'b1;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      insn        <= '0;
      work_en     <= 1'b0;
      num_insn_q  <= '0;
      issued_cnt  <= '0;
      data_num_q  <= '0;
      rd_cnt      <= '0;
      acc_cnt     <= '0;
      timer       <= '0;
      vcu_done_d  <= 1'b0;
      err_timeout <= 1'b0;
      pending     <= 1'b0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      vcu_done_d <= vcu_done;
      work_en    <= 1'b0;
      pending    <= do_read;

      if (state == S_IDLE && start) begin
        num_insn_q  <= num_insn;
        data_num_q  <= data_num;
        issued_cnt  <= '0;
        rd_cnt      <= '0;
        acc_cnt     <= '0;
        err_timeout <= 1'b0;
      end

      if (pop) begin
        insn    <= fifo_head;
        work_en <= (KICK_EACH != 0) || (issued_cnt == 16'd0);
        timer   <= '0;
      end

      if (state == S_WAIT) begin
        if (done_rise)      issued_cnt  <= issued_cnt + 16'd1;
        else if (timed_out) err_timeout <= 1'b1;
        else                timer       <= timer + TW'(1);
      end

      if (do_read) rd_cnt  <= rd_cnt + (AW+1)'(1);
      if (consume) acc_cnt <= acc_cnt + (AW+1)'(1);

      if (out_free) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_valid  <= 1'b1;
          skid_valid <= pending;
          if (pending) skid_data <= r_data_ofmap;
        end else begin
          out_valid <= pending;
          if (pending) out_data <= r_data_ofmap;
        end
      end else if (pending) begin
        skid_data  <= r_data_ofmap;
        skid_valid <= 1'b1;
      end

      if (abort) begin
        work_en    <= 1'b0;
        pending    <= 1'b0;
        skid_valid <= 1'b0;
        out_valid  <= 1'b0;
      end
    end
  end

endmodule
